// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle byte/half/word data memory for the MEM stage with wait-state stall and fault reporting
module data_mem_ctrl #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_value,
    output logic [31:0] MEM_OUT,
    output logic        stall,
    output logic        ready,
    output logic        fault
);
    localparam int          AW = $clog2(4 * DEPTH);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic [31:0]   mem_out_q, mem_out_d;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset, rd_word, lane, ld_data, wr_data;
    logic [3:0]    be;
    logic [AW-3:0] idx;
    logic          req, bad, commit;
    // Address decode, legality check, lane extraction and store byte enables
    always_comb begin
        offset  = ALU_result - BASE_ADDR;
        idx     = offset[AW-1:2];
        req     = MEM_R_EN | MEM_W_EN;
        bad     = (MEM_R_EN & MEM_W_EN) | (SIZE == 2'b11) | (offset >= 32'(4 * DEPTH))
                | ((SIZE == 2'b01) & ALU_result[0]) | ((SIZE == 2'b10) & (|ALU_result[1:0]));
        rd_word = mem[idx];
        lane    = rd_word >> {ALU_result[1:0], 3'b000};
        ld_data = (SIZE == 2'b00) ? {{24{SIGNED & lane[7]}}, lane[7:0]}
                : (SIZE == 2'b01) ? {{16{SIGNED & lane[15]}}, lane[15:0]} : rd_word;
        wr_data = (SIZE == 2'b00) ? {4{ST_value[7:0]}} : (SIZE == 2'b01) ? {2{ST_value[15:0]}} : ST_value;
        be      = (SIZE == 2'b00) ? 4'b0001 << ALU_result[1:0]
                : (SIZE == 2'b01) ? (ALU_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        commit  = !rst & req & !bad & (((state_q == IDLE) & (WS == 4'd0)) | ((state_q == BUSY) & (cnt_q == 4'd1)));
    end
    // Next-state logic: IDLE accepts a request, BUSY counts wait states, DONE presents the result for one cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        mem_out_d = mem_out_q;
        if (state_q == IDLE && req) begin
            fault_d   = bad;
            mem_out_d = '0;
            state_d   = (bad || WS == 4'd0) ? DONE : BUSY;
            cnt_d     = bad ? 4'd0 : WS;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? DONE : BUSY;
        end else if (state_q == DONE) begin
            state_d   = IDLE;
            fault_d   = 1'b0;
            mem_out_d = '0;
        end
        if (commit && MEM_R_EN)
            mem_out_d = ld_data;
    end
    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            mem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            mem_out_q <= mem_out_d;
        end
    end
    // Storage array: only the addressed lanes change on a store commit; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && MEM_W_EN)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
    assign stall   = !rst & (((state_q == IDLE) & req) | (state_q == BUSY));
    assign ready   = state_q == DONE;
    assign fault   = ready & fault_q;
    assign MEM_OUT = ready ? mem_out_q : 32'h0;
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised multi-cycle data memory for the MEM stage of the pipelined MIPS core. Supports byte, halfword and word loads/stores with sign/zero extension, a configurable base address and depth, and a configurable number of wait states that stalls the pipeline through a stall/ready handshake. Misaligned or out-of-range accesses are suppressed and reported as a one-cycle fault instead of corrupting memory.

## Interface
- DEPTH, 64: memory size in 32-bit words; power of two, 4..4096.
- BASE_ADDR, 32'h0000_0400: byte address of word 0; multiple of 4*DEPTH.
- WAIT_STATES, 2: extra stall cycles per access, 0..15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- SIZE  in  2  00 byte, 01 half, 10 word; 11 is a fault.
- SIGNED  in  1  loads: 1 sign-extend, 0 zero-extend.
- ALU_result  in  32  byte address.
- ST_value  in  32  store data; byte/half taken from LSBs.
- MEM_OUT  out  32  load data, valid while ready=1; 0 otherwise.
- stall  out  1  hold the pipeline; MEM-stage inputs must stay stable.
- ready  out  1  one-cycle pulse: access complete, pipeline may advance.
- fault  out  1  with ready: access suppressed (misaligned, out of range, SIZE=11, or both enables set).

## Operation
- States: IDLE, BUSY, DONE. Wait counter 4 bits.
- IDLE, no request: stall=0, ready=0.
- IDLE, request (either enable high): stall=1 combinationally this cycle. Valid request with WAIT_STATES=0 commits at this edge -> DONE; valid with WAIT_STATES>0 loads counter=WAIT_STATES -> BUSY; faulting request -> DONE with fault flag set, no commit.
- BUSY: stall=1; counter decrements each cycle; commit occurs at the edge where counter==1, then -> DONE.
- DONE: stall=0, ready=1, fault=flag, MEM_OUT=registered load data (0 for stores or faults). Request inputs ignored this cycle. -> IDLE unconditionally.
- Address check: offset = ALU_result - BASE_ADDR (32-bit unsigned); in range iff offset < 4*DEPTH. Alignment: half needs addr[0]=0, word needs addr[1:0]=00.
- Word index = offset[log2(4*DEPTH)-1:2]. Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
- Store commit writes only the selected lanes; other bytes preserved.
- Load commit captures selected lane, extended to 32 bits per SIGNED, into MEM_OUT register.
- Memory contents are not cleared by reset; undefined until written.

## Timing
- Reset: state IDLE, counter 0, MEM_OUT=0, ready=0, fault=0, stall=0 (stall forced 0 while rst=1).
- Valid access: stall high for exactly WAIT_STATES+1 cycles starting with the request cycle; ready in the next cycle; total WAIT_STATES+2 cycles per access.
- Faulting access: stall for 1 cycle, then ready=1, fault=1 for 1 cycle; memory unchanged.
- Back-to-back accesses: new request recognised in the IDLE cycle immediately after DONE; no bubble beyond DONE.
- Reset during BUSY: access abandoned; store not committed if reset precedes the commit edge; next cycle IDLE with all outputs at reset values.
- Load following store to same word: returns the stored data (commit precedes next access).

## Test plan
- WAIT_STATES=2: word store 0xDEADBEEF to 0x400, then word load from 0x400 -> stall high 3 cycles each, ready pulse in 4th, MEM_OUT=0xDEADBEEF.
- Byte store 0x80 to 0x405 over word 0x11223344 at 0x404, then lb/lbu 0x405 -> word 0x11228044; lb=0xFFFFFF80, lbu=0x00000080.
- Halfword load, SIGNED=1, from 0x406 of 0x8001_2345 -> 0xFFFF8001; from 0x402 (misaligned only at 0x401) -> 0x401 half: fault=1, MEM_OUT=0, stall 1 cycle.
- Out of range: word store to 0x3FC and 0x500 (DEPTH=64) -> fault=1, no memory change verified by readback.
- WAIT_STATES=0: alternating store/load stream -> every access stall 1 cycle, ready next cycle, data correct.
- Reset asserted in BUSY of a store to 0x408 -> outputs cleared next cycle, later load of 0x408 returns prior contents.
